// File: rtl/dpram_pkg.sv
// Purpose: shared constants, sweep state type and the byte-lane merge helper for the RAM.
// Latency: none (declarations only).
// Backpressure: none.
package dpram_pkg;

  localparam int RDW_OLD = 0;  // read-during-write returns the pre-write word
  localparam int RDW_NEW = 1;  // read-during-write returns the post-write word
  localparam int PRIO_P0 = 0;  // port 0 wins a contested byte lane
  localparam int PRIO_P1 = 1;  // port 1 wins a contested byte lane

  // be_merge works on a fixed wide word so any DATA_W up to MERGE_W can share it;
  // callers cast their operands up and the result back down.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sweep_state_t;

  // Lane b of the result comes from new_w when be[b] is set, else from old_w.
  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_w,
    input logic [MERGE_W-1:0]    new_w,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MERGE_BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dual_port_ram_be_if.sv
// Purpose: request/response bundle of the 2W/2R byte-enabled RAM.
// Latency: none (wiring only); read responses arrive one cycle after the request.
// Backpressure: none; init_busy tells the master its requests are being ignored.
// Ports: write_en/addr/data_{0,1}, read_en/addr_{0,1} (master -> RAM);
//        read_data/valid_{0,1}, wr_collision, init_busy (RAM -> master).
interface dual_port_ram_be_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int BE_W = DATA_W / 8;

  logic [BE_W-1:0]   write_en_0;
  logic [ADDR_W-1:0] write_addr_0;
  logic [DATA_W-1:0] write_data_0;
  logic [BE_W-1:0]   write_en_1;
  logic [ADDR_W-1:0] write_addr_1;
  logic [DATA_W-1:0] write_data_1;
  logic              read_en_0;
  logic [ADDR_W-1:0] read_addr_0;
  logic [DATA_W-1:0] read_data_0;
  logic              read_valid_0;
  logic              read_en_1;
  logic [ADDR_W-1:0] read_addr_1;
  logic [DATA_W-1:0] read_data_1;
  logic              read_valid_1;
  logic              wr_collision;
  logic              init_busy;

  modport master (
    output write_en_0, write_addr_0, write_data_0,
    output write_en_1, write_addr_1, write_data_1,
    output read_en_0, read_addr_0, read_en_1, read_addr_1,
    input  read_data_0, read_valid_0, read_data_1, read_valid_1,
    input  wr_collision, init_busy
  );

  modport slave (
    input  write_en_0, write_addr_0, write_data_0,
    input  write_en_1, write_addr_1, write_data_1,
    input  read_en_0, read_addr_0, read_en_1, read_addr_1,
    output read_data_0, read_valid_0, read_data_1, read_valid_1,
    output wr_collision, init_busy
  );

endinterface

// File: rtl/dpram_init_seq.sv
// Purpose: post-reset sweep that writes the init value into every RAM word.
// Latency: init_busy stays high for exactly 2**ADDR_W cycles after rst falls.
// Backpressure: none; the sweep cannot be stalled, only restarted by rst.
// Ports: clk, rst (sync, active high); init_busy, sweep_we, sweep_addr to the RAM.
module dpram_init_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  sweep_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    init_busy = 1'b0;
    sweep_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        init_busy = 1'b1;
        // No write on the reset cycle itself; the sweep starts on the first edge after rst drops.
        sweep_we  = ~rst;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = READY;
      end
      default: begin
      end
    endcase
  end

  assign sweep_addr = ptr_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// Purpose: 2-write/2-read register-file RAM with byte enables, collision resolution and init sweep.
// Latency: reads 1 cycle (registered data + valid); writes visible to reads on the next cycle.
// Backpressure: none; while init_busy is high all user reads and writes are dropped.
// Ports: clk, rst (sync, active high); bus (slave modport): two write ports (en/addr/data),
//        two read ports (en/addr -> data/valid), wr_collision pulse, init_busy.
module dual_port_ram_be
  import dpram_pkg::*;
#(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 4,
  parameter int                RDW_MODE     = RDW_OLD,
  parameter int                WR_PRIORITY  = PRIO_P0,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
  input  logic                clk,
  input  logic                rst,
  dual_port_ram_be_if.slave   bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_busy;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  dpram_init_seq #(
    .ADDR_W       (ADDR_W),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .init_busy  (init_busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // Word at addr after this cycle's writes. Masks are already resolved, so on a
  // shared address they are disjoint and the order of the two merges is irrelevant.
  function automatic logic [DATA_W-1:0] post_word(
    input logic [DATA_W-1:0] cur,
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic [BE_W-1:0]   m0,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1,
    input logic [BE_W-1:0]   m1
  );
    logic [BE_W-1:0]   k0, k1;
    logic [DATA_W-1:0] w;
    k0 = (addr == a0) ? m0 : '0;
    k1 = (addr == a1) ? m1 : '0;
    w  = DATA_W'(be_merge(MERGE_W'(cur), MERGE_W'(d0), MERGE_BE_W'(k0)));
    w  = DATA_W'(be_merge(MERGE_W'(w),   MERGE_W'(d1), MERGE_BE_W'(k1)));
    return w;
  endfunction

  logic              user_ok;
  logic              same_addr;
  logic [BE_W-1:0]   both_en;
  logic [BE_W-1:0]   en0_win, en1_win;
  logic [DATA_W-1:0] wr_word_0, wr_word_1;
  logic [DATA_W-1:0] rd_new_0, rd_new_1;

  assign user_ok   = ~rst & ~init_busy;
  assign same_addr = (bus.write_addr_0 == bus.write_addr_1);
  // Lanes both ports want on the same word; the lower-priority port gives up only these.
  assign both_en   = same_addr ? (bus.write_en_0 & bus.write_en_1) : '0;

  assign en0_win = !user_ok ? '0 :
                   (WR_PRIORITY == PRIO_P1) ? (bus.write_en_0 & ~both_en) : bus.write_en_0;
  assign en1_win = !user_ok ? '0 :
                   (WR_PRIORITY == PRIO_P0) ? (bus.write_en_1 & ~both_en) : bus.write_en_1;

  assign wr_word_0 = post_word(mem[bus.write_addr_0], bus.write_addr_0,
                               bus.write_addr_0, bus.write_data_0, en0_win,
                               bus.write_addr_1, bus.write_data_1, en1_win);
  assign wr_word_1 = post_word(mem[bus.write_addr_1], bus.write_addr_1,
                               bus.write_addr_0, bus.write_data_0, en0_win,
                               bus.write_addr_1, bus.write_data_1, en1_win);
  assign rd_new_0  = post_word(mem[bus.read_addr_0], bus.read_addr_0,
                               bus.write_addr_0, bus.write_data_0, en0_win,
                               bus.write_addr_1, bus.write_data_1, en1_win);
  assign rd_new_1  = post_word(mem[bus.read_addr_1], bus.read_addr_1,
                               bus.write_addr_0, bus.write_data_0, en0_win,
                               bus.write_addr_1, bus.write_data_1, en1_win);

  // Both ports store the fully merged word, so a shared address gets identical values.
  always_ff @(posedge clk) begin
    if (sweep_we)  mem[sweep_addr]       <= INIT_VAL;
    if (|en0_win)  mem[bus.write_addr_0] <= wr_word_0;
    if (|en1_win)  mem[bus.write_addr_1] <= wr_word_1;
  end

  logic [DATA_W-1:0] rd_data_0_q, rd_data_1_q;
  logic              rd_vld_0_q, rd_vld_1_q, collision_q;
  logic              rd_acc_0, rd_acc_1;

  assign rd_acc_0 = bus.read_en_0 & ~init_busy;
  assign rd_acc_1 = bus.read_en_1 & ~init_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_0_q <= '0;
      rd_data_1_q <= '0;
      rd_vld_0_q  <= 1'b0;
      rd_vld_1_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      rd_vld_0_q  <= rd_acc_0;
      rd_vld_1_q  <= rd_acc_1;
      collision_q <= (|both_en) & ~init_busy;
      if (rd_acc_0) rd_data_0_q <= (RDW_MODE == RDW_NEW) ? rd_new_0 : mem[bus.read_addr_0];
      if (rd_acc_1) rd_data_1_q <= (RDW_MODE == RDW_NEW) ? rd_new_1 : mem[bus.read_addr_1];
    end
  end

  assign bus.read_data_0  = rd_data_0_q;
  assign bus.read_data_1  = rd_data_1_q;
  assign bus.read_valid_0 = rd_vld_0_q;
  assign bus.read_valid_1 = rd_vld_1_q;
  assign bus.wr_collision = collision_q;
  assign bus.init_busy    = init_busy;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Purpose: self-checking bench for dual_port_ram_be across three parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_dual_port_ram_be;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [BW-1:0] we0, we1;
  logic [AW-1:0] wa0, wa1, ra0, ra1;
  logic [DW-1:0] wd0, wd1;
  logic          re0, re1;

  dual_port_ram_be_if #(.DATA_W(DW), .ADDR_W(AW)) if_a (), if_b (), if_c ();

  assign if_a.write_en_0 = we0; assign if_a.write_addr_0 = wa0; assign if_a.write_data_0 = wd0;
  assign if_a.write_en_1 = we1; assign if_a.write_addr_1 = wa1; assign if_a.write_data_1 = wd1;
  assign if_a.read_en_0 = re0; assign if_a.read_addr_0 = ra0;
  assign if_a.read_en_1 = re1; assign if_a.read_addr_1 = ra1;
  assign if_b.write_en_0 = we0; assign if_b.write_addr_0 = wa0; assign if_b.write_data_0 = wd0;
  assign if_b.write_en_1 = we1; assign if_b.write_addr_1 = wa1; assign if_b.write_data_1 = wd1;
  assign if_b.read_en_0 = re0; assign if_b.read_addr_0 = ra0;
  assign if_b.read_en_1 = re1; assign if_b.read_addr_1 = ra1;
  assign if_c.write_en_0 = we0; assign if_c.write_addr_0 = wa0; assign if_c.write_data_0 = wd0;
  assign if_c.write_en_1 = we1; assign if_c.write_addr_1 = wa1; assign if_c.write_data_1 = wd1;
  assign if_c.read_en_0 = re0; assign if_c.read_addr_0 = ra0;
  assign if_c.read_en_1 = re1; assign if_c.read_addr_1 = ra1;

  // A: old-data RDW, port 0 priority, clear to 0000.  B: write-through, port 1 priority, clear to A5A5.
  // C: no clear sweep.
  dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .WR_PRIORITY(0),
                     .CLEAR_ON_RST(1), .INIT_VAL(16'h0000)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .WR_PRIORITY(1),
                     .CLEAR_ON_RST(1), .INIT_VAL(16'hA5A5)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .WR_PRIORITY(0),
                     .CLEAR_ON_RST(0), .INIT_VAL(16'h0000)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [DW-1:0] o_rd0 [2], o_rd1 [2];
  logic          o_v0 [2], o_v1 [2], o_col [2], o_busy [2];
  assign o_rd0[0] = if_a.read_data_0;  assign o_rd1[0] = if_a.read_data_1;
  assign o_v0[0]  = if_a.read_valid_0; assign o_v1[0]  = if_a.read_valid_1;
  assign o_col[0] = if_a.wr_collision; assign o_busy[0] = if_a.init_busy;
  assign o_rd0[1] = if_b.read_data_0;  assign o_rd1[1] = if_b.read_data_1;
  assign o_v0[1]  = if_b.read_valid_0; assign o_v1[1]  = if_b.read_valid_1;
  assign o_col[1] = if_b.wr_collision; assign o_busy[1] = if_b.init_busy;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: word array per instance, a countdown of remaining sweep cycles,
  // and the expected registered outputs.
  int            rdw_m [2] = '{0, 1};
  int            prio_m [2] = '{0, 1};
  logic [DW-1:0] init_m [2] = '{16'h0000, 16'hA5A5};
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DW-1:0] e_rd0 [2], e_rd1 [2];
  logic          e_v0 [2], e_v1 [2], e_col [2];
  int            left [2];
  logic          e_cv0, e_cv1, e_ccol;

  task automatic model_step();
    logic [DW-1:0] nxt [DEPTH];
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e_rd0[k] = '0; e_rd1[k] = '0; e_v0[k] = 1'b0; e_v1[k] = 1'b0; e_col[k] = 1'b0;
        left[k] = DEPTH;
      end else if (left[k] > 0) begin
        m_mem[k][DEPTH - left[k]] = init_m[k];
        left[k]--;
        e_v0[k] = 1'b0; e_v1[k] = 1'b0; e_col[k] = 1'b0;
      end else begin
        for (int a = 0; a < DEPTH; a++) nxt[a] = m_mem[k][a];
        e_col[k] = 1'b0;
        for (int b = 0; b < BW; b++) begin
          if (we0[b] && we1[b] && wa0 == wa1) begin
            e_col[k] = 1'b1;
            if (prio_m[k] == 0) nxt[wa0][8*b +: 8] = wd0[8*b +: 8];
            else                nxt[wa1][8*b +: 8] = wd1[8*b +: 8];
          end else begin
            if (we0[b]) nxt[wa0][8*b +: 8] = wd0[8*b +: 8];
            if (we1[b]) nxt[wa1][8*b +: 8] = wd1[8*b +: 8];
          end
        end
        e_v0[k] = re0;
        e_v1[k] = re1;
        if (re0) e_rd0[k] = (rdw_m[k] == 1) ? nxt[ra0] : m_mem[k][ra0];
        if (re1) e_rd1[k] = (rdw_m[k] == 1) ? nxt[ra1] : m_mem[k][ra1];
        for (int a = 0; a < DEPTH; a++) m_mem[k][a] = nxt[a];
      end
    end
    e_cv0  = !rst && re0;
    e_cv1  = !rst && re1;
    e_ccol = !rst && (wa0 == wa1) && ((we0 & we1) != '0);
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk ($sformatf("rd0_%0d", k),  o_rd0[k],  e_rd0[k]);
      chk ($sformatf("rd1_%0d", k),  o_rd1[k],  e_rd1[k]);
      chkb($sformatf("v0_%0d", k),   o_v0[k],   e_v0[k]);
      chkb($sformatf("v1_%0d", k),   o_v1[k],   e_v1[k]);
      chkb($sformatf("col_%0d", k),  o_col[k],  e_col[k]);
      chkb($sformatf("busy_%0d", k), o_busy[k], left[k] > 0);
    end
    chkb("busy_c", if_c.init_busy, 1'b0);
    chkb("v0_c", if_c.read_valid_0, e_cv0);
    chkb("v1_c", if_c.read_valid_1, e_cv1);
    chkb("col_c", if_c.wr_collision, e_ccol);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Called at the sample point right after the last reset edge; counts busy samples.
  task automatic count_busy(input string tag);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_busy[0]) na++;
      if (o_busy[1]) nb++;
      if (!o_busy[0] && !o_busy[1]) break;
      tick();
    end
    chk({tag, "_a"}, DW'(na), 16'd16);
    chk({tag, "_b"}, DW'(nb), 16'd16);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    we0 = '0; we1 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    re0 = 1'b0; re1 = 1'b0; ra0 = '0; ra1 = '0;
    tick(); tick();
    chk ("rst_rd0_a", o_rd0[0], 16'h0000);
    chk ("rst_rd1_b", o_rd1[1], 16'h0000);
    chkb("rst_v0_a", o_v0[0], 1'b0);
    chkb("rst_col_b", o_col[1], 1'b0);
    chkb("rst_busy_a", o_busy[0], 1'b1);
    chkb("rst_busy_c", if_c.init_busy, 1'b0);

    // Clear sweep length and contents.
    rst = 1'b0;
    count_busy("t1_busy");
    for (int a = 0; a < DEPTH; a++) begin
      re0 = 1'b1; re1 = 1'b1; ra0 = AW'(a); ra1 = AW'(DEPTH - 1 - a);
      tick();
      chk("t1_clr_a", o_rd0[0], 16'h0000);
      chk("t1_clr_b", o_rd1[1], 16'hA5A5);
    end
    re0 = 1'b0; re1 = 1'b0;

    // Reset in the middle of the sweep restarts it.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy("t1_restart");

    // Partial-lane write.
    we0 = 2'b11; wa0 = 4'd3; wd0 = 16'hFFFF; tick();
    we0 = 2'b01; wd0 = 16'h1234; tick();
    we0 = '0; re0 = 1'b1; ra0 = 4'd3; tick();
    chk ("t2_rd_a", o_rd0[0], 16'hFF34);
    chk ("t2_rd_b", o_rd0[1], 16'hFF34);
    chkb("t2_v0_a", o_v0[0], 1'b1);
    re0 = 1'b0; tick();
    chkb("t2_v0_drop", o_v0[0], 1'b0);

    // Same-address, same-lane collision, then disjoint lanes.
    we0 = 2'b11; we1 = 2'b11; wa0 = 4'd5; wa1 = 4'd5; wd0 = 16'hAAAA; wd1 = 16'h5555; tick();
    chkb("t3_col_a", o_col[0], 1'b1);
    chkb("t3_col_b", o_col[1], 1'b1);
    we0 = '0; we1 = '0; re0 = 1'b1; ra0 = 4'd5; tick();
    chkb("t3_col_once", o_col[0], 1'b0);
    chk ("t3_prio0", o_rd0[0], 16'hAAAA);
    chk ("t3_prio1", o_rd0[1], 16'h5555);
    re0 = 1'b0; we0 = 2'b10; we1 = 2'b01; tick();
    chkb("t3_nocol_a", o_col[0], 1'b0);
    chkb("t3_nocol_b", o_col[1], 1'b0);
    we0 = '0; we1 = '0; re1 = 1'b1; ra1 = 4'd5; tick();
    chk ("t3_mix_a", o_rd1[0], 16'hAA55);
    chk ("t3_mix_b", o_rd1[1], 16'hAA55);
    re1 = 1'b0;

    // Read-during-write on both read ports.
    we0 = 2'b11; wa0 = 4'd9; wd0 = 16'h1111; tick();
    wd0 = 16'h2222; re0 = 1'b1; re1 = 1'b1; ra0 = 4'd9; ra1 = 4'd9; tick();
    chk("t4_old_p0", o_rd0[0], 16'h1111);
    chk("t4_old_p1", o_rd1[0], 16'h1111);
    chk("t4_new_p0", o_rd0[1], 16'h2222);
    chk("t4_new_p1", o_rd1[1], 16'h2222);
    we0 = '0; tick();
    chk("t4_after", o_rd0[0], 16'h2222);
    re0 = 1'b0; re1 = 1'b0;

    // Requests during the sweep are ignored.
    rst = 1'b1; tick(); rst = 1'b0;
    we0 = 2'b11; wa0 = 4'd2; wd0 = 16'hBEEF;
    we1 = 2'b11; wa1 = 4'd7; wd1 = 16'hCAFE;
    re0 = 1'b1; re1 = 1'b1; ra0 = 4'd2; ra1 = 4'd7;
    nv = 0;
    for (int i = 0; i < 40 && o_busy[0]; i++) begin
      tick();
      if (o_v0[0] | o_v1[0] | o_v0[1] | o_v1[1]) nv++;
    end
    chk("t5_novalid", DW'(nv), 16'd0);
    chkb("t5_done", o_busy[0], 1'b0);
    we0 = '0; we1 = '0; tick();
    chk("t5_a2", o_rd0[0], 16'h0000);
    chk("t5_a7", o_rd1[0], 16'h0000);
    chk("t5_b2", o_rd0[1], 16'hA5A5);
    chk("t5_b7", o_rd1[1], 16'hA5A5);
    re0 = 1'b0; re1 = 1'b0;
    we0 = 2'b11; wa0 = 4'd4; wd0 = 16'h7777; tick();
    we0 = '0; re0 = 1'b1; ra0 = 4'd4; tick();
    chk("t5_rd", o_rd0[0], 16'h7777);
    re0 = 1'b0; ra0 = 4'd2; tick();
    chk ("t5_hold", o_rd0[0], 16'h7777);
    chkb("t5_hold_v", o_v0[0], 1'b0);

    // Random back-to-back traffic; narrow address range half the time to provoke collisions.
    for (int i = 0; i < 10000; i++) begin
      we0 = BW'($urandom_range(0, 3));
      we1 = BW'($urandom_range(0, 3));
      wa0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      wa1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      ra0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      ra1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      wd0 = DW'($urandom);
      wd1 = DW'($urandom);
      re0 = 1'($urandom_range(0, 1));
      re1 = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
